// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit, one radix-2 step per cycle.
// Multiply uses shift-add into a 2*XLEN product; divide uses restoring division.
// Optional build macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and
// multiply-by-zero skip the iterations and report one cycle after acceptance.
module muldiv_unit #(
  parameter int unsigned XLEN = 32,
  localparam int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {StIdle, StBusy, StFixup, StDone} state_e;

  state_e            state_q;
  logic [2:0]        op_q;
  logic [CNT_W-1:0]  cnt_q;
  // Multiply: opnd = |multiplicand|, lo = |multiplier| shifting out, hi = product high.
  // Divide:   opnd = |divisor|, lo = |dividend| shifting out / quotient in, hi = remainder.
  logic [XLEN-1:0]   opnd_q;
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              neg_res_q;
  logic              neg_rem_q;
  logic              div_zero_q;
  logic              early_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              busy_q;
  logic [XLEN-1:0]   result_q;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign busy      = busy_q;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   abs_a, abs_b;

  // Operand sign handling at acceptance time
  always_comb begin
    a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
    b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
    a_neg    = a_signed && in1[XLEN-1];
    b_neg    = b_signed && in2[XLEN-1];
    abs_a    = a_neg ? -in1 : in1;
    abs_b    = b_neg ? -in2 : in2;
  end

  logic              special;
  logic [XLEN-1:0]   special_res;

`ifdef MULDIV_EARLY_OUT_EN
  // Detect ops whose result is known without iterating
  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (!op[2]) begin
      special = (in1 == '0) || (in2 == '0);
    end else if (in2 == '0) begin
      special     = 1'b1;
      special_res = op[1] ? in1 : '1;
    end else if (!op[0] && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1)) begin
      special     = 1'b1;
      special_res = op[1] ? '0 : in1;
    end
  end
`else
  // Early-out disabled: every op runs the full iteration count
  always_comb begin
    special     = 1'b0;
    special_res = '0;
  end
`endif

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_trial;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;

  // One iteration step and the final sign correction / result select
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_trial = {hi_q, lo_q[XLEN-1]} - {1'b0, opnd_q};
    prod      = {hi_q, lo_q};
    prod_fix  = neg_res_q ? -prod : prod;
    // Restoring division yields all-ones quotient for a zero divisor, but the
    // signed correction would flip it, so force it here.
    quo_fix   = div_zero_q ? '1 : (neg_res_q ? -lo_q : lo_q);
    rem_fix   = neg_rem_q ? -hi_q : hi_q;
    unique case (op_q)
      3'd0:                   fix_res = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3:       fix_res = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:             fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q     <= StIdle;
      op_q        <= '0;
      cnt_q       <= '0;
      opnd_q      <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      neg_res_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      div_zero_q  <= 1'b0;
      early_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid && in_ready_q) begin
            op_q       <= op;
            cnt_q      <= '0;
            hi_q       <= '0;
            neg_res_q  <= a_neg ^ b_neg;
            neg_rem_q  <= a_neg;
            div_zero_q <= op[2] && (in2 == '0);
            early_q    <= special;
            result_q   <= special_res;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            if (op[2]) begin
              opnd_q <= abs_b;
              lo_q   <= abs_a;
            end else begin
              opnd_q <= abs_a;
              lo_q   <= abs_b;
            end
            state_q <= special ? StFixup : StBusy;
          end
        end
        StBusy: begin
          if (op_q[2]) begin
            hi_q <= div_trial[XLEN] ? {hi_q[XLEN-2:0], lo_q[XLEN-1]} : div_trial[XLEN-1:0];
            lo_q <= {lo_q[XLEN-2:0], ~div_trial[XLEN]};
          end else begin
            {hi_q, lo_q} <= {mul_sum, lo_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            cnt_q   <= CNT_W'(XLEN);
            state_q <= StFixup;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StFixup: begin
          // Early-out ops already hold their result; just forward it
          if (!early_q) begin
            result_q <= fix_res;
          end
          out_valid_q <= 1'b1;
          state_q     <= StDone;
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (XLEN=32 main instance, XLEN=16 spot check).
// Expected results come from a behavioural RV32M model pushed into a scoreboard.
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, flush, in_valid, out_ready;
  logic [2:0]  op;
  logic [31:0] in1, in2, result;
  logic        in_ready, out_valid, busy;

  logic        in_valid16, out_ready16, in_ready16, out_valid16, busy16;
  logic [2:0]  op16;
  logic [15:0] a16, b16, result16;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];
  int          lat_q[$];

  muldiv_unit #(.XLEN(32)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in1(in1), .in2(in2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  muldiv_unit #(.XLEN(16)) u_dut16 (
    .clk(clk), .reset(reset), .flush(1'b0), .in_valid(in_valid16), .in_ready(in_ready16),
    .op(op16), .in1(a16), .in2(b16), .out_valid(out_valid16), .out_ready(out_ready16),
    .result(result16), .busy(busy16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    ub  = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[2] && (a == 0 || b == 0)) return 1;
    if (o[2] && b == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`endif
    return 33;
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("accept_ready", in_ready, 1);
    op = o; in1 = a; in2 = b; in_valid = 1'b1;
    exp_q.push_back(model(o, a, b));
    lat_q.push_back(exp_lat(o, a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in1 = $urandom; in2 = $urandom; op = 3'($urandom);
  endtask

  task automatic wait_result(output logic [31:0] exp);
    int n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    exp = exp_q.pop_front();
    check("latency", n, lat_q.pop_front());
    check("result", result, exp);
    check("ready_while_valid", in_ready, 0);
  endtask

  task automatic release_result(input int hold, input logic [31:0] exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_result", result, exp);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_ready", in_ready, 1);
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input int hold);
    logic [31:0] e;
    issue(o, a, b);
    wait_result(e);
    release_result(hold, e);
  endtask

  initial begin
    logic [31:0] e;
    logic        seen;
    int          n;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = '0; in1 = '0; in2 = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b0; op16 = '0; a16 = '0; b16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_result", result, 0);
    @(negedge clk); reset = 1'b0;

    // Directed cases
    run(3'd0, 32'd7, 32'hFFFF_FFFD, 3);
    run(3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(3'd4, -32'sd20, 32'd6, 0);
    run(3'd6, -32'sd20, 32'd6, 0);
    run(3'd5, 32'd20, 32'd6, 0);
    run(3'd5, 32'h1234, 32'd0, 0);
    run(3'd7, 32'h1234, 32'd0, 0);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run(3'd4, -32'sd5, 32'd0, 0);
    run(3'd6, -32'sd5, 32'd0, 1);
    run(3'd0, 32'd0, 32'd99, 0);
    run(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0);

    // Random operations
    for (int i = 0; i < 24; i++) begin
      run(3'($urandom), $urandom, (i % 6 == 5) ? 32'($urandom_range(0, 3)) : $urandom,
          $urandom_range(0, 2));
    end

    // Flush mid-iteration: no result may ever appear
    @(negedge clk);
    op = 3'd0; in1 = 32'd3; in2 = 32'd5; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    check("flush_ready", in_ready, 1);
    check("flush_busy", busy, 0);
    check("flush_valid", out_valid, 0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("flush_no_output", seen, 0);

    // Flush beats a coincident accept
    @(negedge clk); in_valid = 1'b1; flush = 1'b1; op = 3'd5; in1 = 32'd9; in2 = 32'd3;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    check("flush_accept_busy", busy, 0);
    check("flush_accept_ready", in_ready, 1);

    // Reset while a result is waiting
    issue(3'd5, 32'd100, 32'd7);
    wait_result(e);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1; reset = 1'b0;
    check("rst_done_valid", out_valid, 0);
    check("rst_done_result", result, 0);
    check("rst_done_ready", in_ready, 1);
    run(3'd7, 32'd100, 32'd7, 0);

    // XLEN=16 instance
    @(negedge clk); in_valid16 = 1'b1; op16 = 3'd0; a16 = 16'h0007; b16 = 16'hFFFD;
    @(posedge clk); #1; in_valid16 = 1'b0;
    n = 0;
    while (!out_valid16 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("x16_latency", n, 17);
    check("x16_result", result16, 16'hFFEB);
    @(negedge clk); out_ready16 = 1'b1;
    @(posedge clk); #1; out_ready16 = 1'b0;
    check("x16_release", out_valid16, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
